match_controller: RTL and testbench

Round and match sequencer for the street-fighter game core. It holds the game core in reset during pre-round countdowns and releases it for the fight. It watches the core's `finish` code, tallies round wins to a best-of-N match winner, and supports pause. It sits between the board buttons and the `game` block, driving the core's active-low reset and gating player inputs. It also exports phase and countdown state to the VGA renderer.

---
 rtl/match_pkg.sv | 17 +
 rtl/match_controller_sec_tick_gen.sv | 27 ++
 rtl/match_controller.sv | 153 +++++++++++++++
 tb/tb_match_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared phase encoding and finish codes for the match controller and the VGA overlay.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INTRO     = 3'd1,
    FIGHT     = 3'd2,
    PAUSE     = 3'd3,
    ROUND_END = 3'd4,
    MATCH_END = 3'd5
  } phase_e;

  localparam logic [1:0] RUNNING = 2'b00;
  localparam logic [1:0] P1_WIN  = 2'b01;
  localparam logic [1:0] P2_WIN  = 2'b11;

endpackage

// File: rtl/match_controller_sec_tick_gen.sv
// One-second tick generator: counts 0..TERMINAL-1 and flags the terminal count.
module sec_tick_gen #(
  parameter int TERMINAL = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic sec_tick
);

  localparam int              CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign sec_tick = (cnt == LAST);

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: holds the game core in reset through countdowns, tallies
// round wins to a best-of-N match winner and supports pause.
module match_controller
  import match_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 100_000_000,
  parameter int COUNTDOWN_SECS = 3,
  parameter int END_HOLD_SECS  = 2,
  parameter int ROUNDS_TO_WIN  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic [1:0] finish,
  output logic       game_rst_n,
  output logic       inputs_enable,
  output logic [2:0] phase,
  output logic [1:0] countdown,
  output logic [2:0] round_num,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] match_winner
);

  localparam int              HOLD_W    = $clog2(END_HOLD_SECS + 1);
  localparam logic [1:0]      CD_INIT   = 2'(COUNTDOWN_SECS);
  localparam logic [1:0]      WIN_CNT   = 2'(ROUNDS_TO_WIN);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(END_HOLD_SECS);

  logic [1:0]        rst_sync;
  logic              rst_n;
  phase_e            state;
  logic              start_prev;
  logic              start_edge;
  logic              sec_tick;
  logic              tick_clr;
  logic [HOLD_W-1:0] hold_cnt;

  // NOTE: reset asserts asynchronously but releases only after two clean clk
  // edges, so no flop sees a deassertion close to its active edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign start_edge = start_btn & ~start_prev;
  assign phase      = state;

  // Restart the second counter on every state change so each second is full length.
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    tick_clr = 1'b0;
    case (state)
      IDLE, MATCH_END: tick_clr = start_edge;
      INTRO:           tick_clr = sec_tick && (countdown == 2'd1);
      FIGHT, PAUSE:    tick_clr = finish[0] || start_edge;
      ROUND_END:       tick_clr = sec_tick && (hold_cnt == HOLD_W'(1));
      default:         tick_clr = 1'b1;
    endcase
  end

  sec_tick_gen #(.TERMINAL(TICKS_PER_SEC)) u_sec_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tick_clr),
    .sec_tick (sec_tick)
  );

  // NOTE: all state and outputs update with non-blocking assignments so every
  // decision below reads the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_prev    <= 1'b1;
      game_rst_n    <= 1'b0;
      inputs_enable <= 1'b0;
      countdown     <= 2'd0;
      round_num     <= 3'd1;
      p1_rounds     <= 2'd0;
      p2_rounds     <= 2'd0;
      match_winner  <= RUNNING;
      hold_cnt      <= '0;
    end else begin
      start_prev <= start_btn;
      case (state)
        IDLE, MATCH_END: begin
          if (start_edge) begin
            state         <= INTRO;
            countdown     <= CD_INIT;
            round_num     <= 3'd1;
            p1_rounds     <= 2'd0;
            p2_rounds     <= 2'd0;
            match_winner  <= RUNNING;
            game_rst_n    <= 1'b0;
            inputs_enable <= 1'b0;
          end
        end
        INTRO: begin
          if (sec_tick) begin
            if (countdown == 2'd1) begin
              state         <= FIGHT;
              countdown     <= 2'd0;
              game_rst_n    <= 1'b1;
              inputs_enable <= 1'b1;
            end else begin
              countdown <= countdown - 2'd1;
            end
          end
        end
        FIGHT, PAUSE: begin
          // A round result outranks a same-cycle pause toggle.
          if (finish[0]) begin
            if (finish[1]) begin
              if (p2_rounds != WIN_CNT) p2_rounds <= p2_rounds + 2'd1;
            end else begin
              if (p1_rounds != WIN_CNT) p1_rounds <= p1_rounds + 2'd1;
            end
            state         <= ROUND_END;
            inputs_enable <= 1'b0;
            hold_cnt      <= HOLD_INIT;
          end else if (start_edge) begin
            state         <= (state == FIGHT) ? PAUSE : FIGHT;
            inputs_enable <= (state == PAUSE);
          end
        end
        ROUND_END: begin
          if (sec_tick) begin
            if (hold_cnt == HOLD_W'(1)) begin
              if (p1_rounds == WIN_CNT || p2_rounds == WIN_CNT) begin
                state        <= MATCH_END;
                match_winner <= (p1_rounds == WIN_CNT) ? P1_WIN : P2_WIN;
              end else begin
                state      <= INTRO;
                round_num  <= round_num + 3'd1;
                countdown  <= CD_INIT;
                game_rst_n <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
        end
        default: begin
          state         <= IDLE;
          game_rst_n    <= 1'b0;
          inputs_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Randomized scoreboard bench for match_controller against a phase/elapsed-time model.
module tb_match_controller;
  import match_pkg::*;

  localparam int T = 10;
  localparam int C = 3;
  localparam int H = 2;
  localparam int R = 2;
  localparam int N_CYCLES = 6000;

  typedef struct packed {
    logic [2:0] ph;
    logic       grst;
    logic       ie;
    logic [1:0] cd;
    logic [2:0] rnd;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] win;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [1:0] finish;
  logic       game_rst_n, inputs_enable;
  logic [2:0] phase, round_num;
  logic [1:0] countdown, p1_rounds, p2_rounds, match_winner;
  obs_t       act;

  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  // Reference model: phase plus cycles spent in it; timing derived from elapsed cycles.
  phase_e m_phase;
  int     m_el, m_round, m_p1, m_p2, m_win, m_rel;
  logic   m_prev;

  match_controller #(
    .TICKS_PER_SEC (T), .COUNTDOWN_SECS (C), .END_HOLD_SECS (H), .ROUNDS_TO_WIN (R)
  ) dut (
    .clk (clk), .reset (reset), .start_btn (start_btn), .finish (finish),
    .game_rst_n (game_rst_n), .inputs_enable (inputs_enable), .phase (phase),
    .countdown (countdown), .round_num (round_num), .p1_rounds (p1_rounds),
    .p2_rounds (p2_rounds), .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  assign act = {phase, game_rst_n, inputs_enable, countdown, round_num,
                p1_rounds, p2_rounds, match_winner};

  function automatic string fmt(input obs_t o);
    return $sformatf("ph=%0d grst=%0b ie=%0b cd=%0d rnd=%0d p1=%0d p2=%0d win=%b",
                     o.ph, o.grst, o.ie, o.cd, o.rnd, o.p1, o.p2, o.win);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got {%s} want {%s}", name, $time, fmt(got), fmt(want));
    end
  endtask

  task automatic model_reset();
    m_phase = IDLE; m_el = 0; m_round = 1; m_p1 = 0; m_p2 = 0; m_win = 0; m_prev = 1'b1;
  endtask

  task automatic enter(input phase_e p);
    m_phase = p;
    m_el    = 0;
  endtask

  // Advance the model across one rising clk edge with the given inputs.
  task automatic model_edge(input logic s, input logic [1:0] f);
    logic se;
    if (!reset) begin
      model_reset();
      m_rel = 0;
      return;
    end
    if (m_rel < 2) begin
      m_rel++;
      model_reset();
      return;
    end
    se = s && !m_prev;
    m_prev = s;
    case (m_phase)
      IDLE, MATCH_END:
        if (se) begin
          enter(INTRO); m_round = 1; m_p1 = 0; m_p2 = 0; m_win = 0;
        end else m_el++;
      INTRO:
        if (m_el == C * T - 1) enter(FIGHT);
        else m_el++;
      FIGHT, PAUSE:
        if (f[0]) begin
          if (f[1]) m_p2 = (m_p2 + 1 > R) ? R : m_p2 + 1;
          else      m_p1 = (m_p1 + 1 > R) ? R : m_p1 + 1;
          enter(ROUND_END);
        end else if (se) enter(m_phase == FIGHT ? PAUSE : FIGHT);
        else m_el++;
      ROUND_END:
        if (m_el == H * T - 1) begin
          if (m_p1 == R)      begin m_win = 1; enter(MATCH_END); end
          else if (m_p2 == R) begin m_win = 2; enter(MATCH_END); end
          else begin m_round++; enter(INTRO); end
        end else m_el++;
      default: enter(IDLE);
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.ph   = m_phase;
    o.grst = (m_phase == FIGHT || m_phase == PAUSE || m_phase == ROUND_END || m_phase == MATCH_END);
    o.ie   = (m_phase == FIGHT);
    o.cd   = (m_phase == INTRO) ? 2'(C - m_el / T) : 2'd0;
    o.rnd  = 3'(m_round);
    o.p1   = 2'(m_p1);
    o.p2   = 2'(m_p2);
    o.win  = (m_win == 1) ? 2'b01 : (m_win == 2) ? 2'b11 : 2'b00;
    return o;
  endfunction

  // Monitor: one registered output vector per clk edge, compared off-edge.
  initial begin
    obs_t want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("cycle", act, want);
      end
    end
  end

  // Stimulus
  initial begin
    int   rel_at = -1;
    int   hold_start_until = -1;
    bit   did_async = 0;
    int   r;
    obs_t rst_vals;
    rst_vals = '{ph: 3'd0, grst: 1'b0, ie: 1'b0, cd: 2'd0, rnd: 3'd1, p1: 2'd0, p2: 2'd0, win: 2'b00};
    reset = 1'b0; start_btn = 1'b0; finish = RUNNING;
    m_rel = 0;
    model_reset();

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      if (cyc == 3 || cyc == rel_at) reset = 1'b1;
      if (cyc < hold_start_until)      start_btn = 1'b1;
      else if ($urandom_range(15) == 0) start_btn = ~start_btn;
      r = int'($urandom_range(39));
      finish = (r == 0) ? P1_WIN : (r == 1) ? P2_WIN : (r == 2) ? 2'b10 : RUNNING;

      if (!did_async && cyc > 1500 && m_phase == ROUND_END && m_el < 10) begin
        model_edge(start_btn, finish);
        exp_q.push_back(model_obs());
        // Assert reset mid-cycle; outputs must drop without a clk edge.
        @(posedge clk);
        #3;
        reset = 1'b0;
        start_btn = 1'b1;
        #1;
        check("async_reset", act, rst_vals);
        did_async = 1;
        rel_at = cyc + 4;
        hold_start_until = cyc + 12;
      end else begin
        model_edge(start_btn, finish);
        exp_q.push_back(model_obs());
      end
    end

    repeat (3) @(negedge clk);
    if (!did_async) begin
      miscompares++;
      $display("FAIL async_reset_reached got=0 want=1");
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
